// File: rtl/spi_reg_bridge.sv
// SPI byte-stream to register-bus bridge: decodes a command byte, assembles
// write words MSB-first, issues read/write strobes and serves read bytes back.
module spi_reg_bridge #(
  parameter int ADDR_W     = 7,
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    spi_ss,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [7:0]              tx_byte,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  output logic                    frame_abort
);

  localparam int WW = 8 * DATA_BYTES;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WW-1:0]     wdata_q, wdata_d;
  logic [WW-1:0]     rword_q, rword_d;
  logic [7:0]        tx_q, tx_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              cap_q, cap_d;
  logic              abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    tx_d    = tx_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cap_d   = cap_q;
    abort_d = abort_q;
    if (ena) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      abort_d = 1'b0;
      cap_d   = rd_q;
      // Address advances only after the write strobe has been seen on the bus.
      if (wr_q)
        addr_d = addr_q + ADDR_W'(1);
      if (cap_q && state_q == S_RDATA) begin
        rword_d = reg_rdata;
        tx_d    = reg_rdata[WW-1 -: 8];
      end
      if (spi_ss) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 8'h00;
        if (state_q == S_WDATA && cnt_q != '0)
          abort_d = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: state_d = S_CMD;
          S_CMD: begin
            if (rx_valid) begin
              addr_d = rx_byte[ADDR_W-1:0];
              cnt_d  = '0;
              if (rx_byte[7]) begin
                state_d = S_RDATA;
                rd_d    = 1'b1;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (rx_valid) begin
              wdata_d = (wdata_q << 8) | WW'(rx_byte);
              if (cnt_q == LAST) begin
                cnt_d = '0;
                wr_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
          S_RDATA: begin
            if (rx_valid) begin
              if (cnt_q == LAST) begin
                cnt_d  = '0;
                addr_d = addr_q + ADDR_W'(1);
                rd_d   = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
                tx_d  = 8'(rword_q >> (8 * (DATA_BYTES - 2 - int'(cnt_q))));
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      tx_q    <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      abort_q <= abort_d;
    end
  end

  // Strobes are held internally while disabled but never reach the bus.
  assign reg_wr      = wr_q & ena;
  assign reg_rd      = rd_q & ena;
  assign frame_abort = abort_q & ena;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign tx_byte     = tx_q;

endmodule
